// File: rtl/cache_pkg.sv
// cache_pkg: shared definitions for the set-associative cache storage array.
// Holds the fixed upper bounds for way/age state, the generic address field
// extractor and the true-LRU age initialisation and update functions.
package cache_pkg;

    // Up to 8 ways; each way carries a 3-bit age field inside a packed vector.
    localparam int MAX_WAYS_WIDTH = 3;
    localparam int MAX_WAYS       = 8;
    localparam int AGE_FIELD      = 3;

    typedef logic [MAX_WAYS*AGE_FIELD-1:0] age_vec_t;

    // Extract an address field of 'width' bits starting at bit 'lsb'.
    function automatic logic [63:0] addr_field(input logic [63:0] a, input int lsb, input int width);
        logic [63:0] mask;
        mask = (64'd1 << width) - 64'd1;
        return (a >> lsb) & mask;
    endfunction

    // Reset ordering: way i starts with age i, so way 0 is the most recent.
    function automatic age_vec_t age_init(input int ways);
        age_vec_t r;
        r = '0;
        for (int i = 0; i < MAX_WAYS; i++) begin
            if (i < ways) begin
                r[i*AGE_FIELD +: AGE_FIELD] = AGE_FIELD'(i);
            end else begin
                r[i*AGE_FIELD +: AGE_FIELD] = 3'd0;
            end
        end
        return r;
    endfunction

    // Move 'way' to age 0; every way younger than its old age gets one older.
    // Ages stay a permutation of 0..ways-1.
    function automatic age_vec_t age_update(input age_vec_t ages, input logic [2:0] way, input int ways);
        age_vec_t   r;
        logic [2:0] old_age;
        logic [2:0] cur;
        r       = ages;
        old_age = ages[int'(way)*AGE_FIELD +: AGE_FIELD];
        for (int i = 0; i < MAX_WAYS; i++) begin
            cur = ages[i*AGE_FIELD +: AGE_FIELD];
            if (i >= ways) begin
                r[i*AGE_FIELD +: AGE_FIELD] = cur;
            end else if (3'(i) == way) begin
                r[i*AGE_FIELD +: AGE_FIELD] = 3'd0;
            end else if (cur < old_age) begin
                r[i*AGE_FIELD +: AGE_FIELD] = cur + 3'd1;
            end else begin
                r[i*AGE_FIELD +: AGE_FIELD] = cur;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/cache_lru.sv
// cache_lru: per-set true-LRU age array.
// Ports: clk, rst (sync, active-high), set (set index), touch_way/touch_en
// (make touch_way most recent in 'set'), victim_way (way with the oldest
// age in 'set', from pre-edge state).
module cache_lru import cache_pkg::*; #(
    parameter  int SET_INDEX_WIDTH = 5,
    parameter  int WAYS_WIDTH      = 1,
    localparam int WAY_W           = (WAYS_WIDTH > 0) ? WAYS_WIDTH : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [SET_INDEX_WIDTH-1:0] set,
    input  logic [WAY_W-1:0]           touch_way,
    input  logic                       touch_en,
    output logic [WAY_W-1:0]           victim_way
);

    localparam int WAYS = 1 << WAYS_WIDTH;
    localparam int SETS = 1 << SET_INDEX_WIDTH;

    if (WAYS_WIDTH == 0) begin : g_one_way
        // A single way has no recency state; the victim is always way 0.
        logic unused_in;
        assign unused_in  = ^{clk, rst, set, touch_way, touch_en};
        assign victim_way = 1'b0;
    end else begin : g_lru
        age_vec_t age_r [SETS];

        // Age state: reset to identity order, otherwise apply the touch.
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int s = 0; s < SETS; s++) begin
                    age_r[s] <= age_init(WAYS);
                end
            end else if (touch_en) begin
                age_r[set] <= age_update(age_r[set], 3'(touch_way), WAYS);
            end
        end

        // Victim: the way whose age is WAYS-1.
        always_comb begin
            victim_way = '0;
            for (int i = 0; i < WAYS; i++) begin
                if (age_r[set][i*AGE_FIELD +: AGE_FIELD] == AGE_FIELD'(WAYS - 1)) begin
                    victim_way = WAY_W'(i);
                end else begin
                    victim_way = victim_way;
                end
            end
        end
    end

endmodule

// File: rtl/cache_assoc.sv
// cache_assoc: N-way set-associative cache storage array.
// Ports: clk, rst (sync, active-high); addr (tag|set|word|byte); commands
// store (refill word), edit (byte-enabled write on hit), invalid (drop hit
// line), touch (mark selected way MRU); be, din write data.
// Registered outputs: hit, sel_way (hit way or victim), dout, valid, dirty,
// tag of sel_way, all reflecting state before this cycle's writes.
module cache_assoc import cache_pkg::*; #(
    parameter  int WORD_BITS        = 32,
    parameter  int ADDR_BITS        = 32,
    parameter  int WORD_BYTES_WIDTH = 2,
    parameter  int LINE_WORDS_WIDTH = 2,
    parameter  int SET_INDEX_WIDTH  = 5,
    parameter  int WAYS_WIDTH       = 1,
    localparam int TAG_BITS         = ADDR_BITS - SET_INDEX_WIDTH - LINE_WORDS_WIDTH - WORD_BYTES_WIDTH,
    localparam int WAY_W            = (WAYS_WIDTH > 0) ? WAYS_WIDTH : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDR_BITS-1:0]   addr,
    input  logic                   store,
    input  logic                   edit,
    input  logic                   invalid,
    input  logic                   touch,
    input  logic [WORD_BITS/8-1:0] be,
    input  logic [WORD_BITS-1:0]   din,
    output logic                   hit,
    output logic [WAY_W-1:0]       sel_way,
    output logic [WORD_BITS-1:0]   dout,
    output logic                   valid,
    output logic                   dirty,
    output logic [TAG_BITS-1:0]    tag
);

    localparam int WAYS       = 1 << WAYS_WIDTH;
    localparam int SETS       = 1 << SET_INDEX_WIDTH;
    localparam int LINE_WORDS = 1 << LINE_WORDS_WIDTH;
    localparam int BYTES      = WORD_BITS / 8;
    localparam int WORD_IDX_W = (LINE_WORDS_WIDTH > 0) ? LINE_WORDS_WIDTH : 1;
    localparam int SET_LSB    = WORD_BYTES_WIDTH + LINE_WORDS_WIDTH;
    localparam int TAG_LSB    = SET_LSB + SET_INDEX_WIDTH;

    logic [WORD_BITS-1:0] data_r  [WAYS][SETS][LINE_WORDS];
    logic [TAG_BITS-1:0]  tag_r   [WAYS][SETS];
    logic                 valid_r [SETS][WAYS];
    logic                 dirty_r [SETS][WAYS];

    logic [TAG_BITS-1:0]        tag_s;
    logic [SET_INDEX_WIDTH-1:0] set_s;
    logic [WORD_IDX_W-1:0]      word_s;
    logic                       hit_c;
    logic [WAY_W-1:0]           hit_way_s;
    logic                       free_found_s;
    logic [WAY_W-1:0]           free_way_s;
    logic [WAY_W-1:0]           victim_way_s;
    logic [WAY_W-1:0]           way_c;

    assign tag_s  = TAG_BITS'(addr_field(64'(addr), TAG_LSB, TAG_BITS));
    assign set_s  = SET_INDEX_WIDTH'(addr_field(64'(addr), SET_LSB, SET_INDEX_WIDTH));
    assign word_s = WORD_IDX_W'(addr_field(64'(addr), WORD_BYTES_WIDTH, LINE_WORDS_WIDTH));

    // Tag compare across ways and lowest-index free-way search.
    always_comb begin
        hit_c        = 1'b0;
        hit_way_s    = '0;
        free_found_s = 1'b0;
        free_way_s   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_r[set_s][w] && (tag_r[w][set_s] == tag_s)) begin
                hit_c     = 1'b1;
                hit_way_s = WAY_W'(w);
            end else begin
                hit_c = hit_c;
            end
            if (!valid_r[set_s][w] && !free_found_s) begin
                free_found_s = 1'b1;
                free_way_s   = WAY_W'(w);
            end else begin
                free_found_s = free_found_s;
            end
        end
    end

    // Way selection: hit way, else first invalid way, else LRU victim.
    always_comb begin
        if (hit_c) begin
            way_c = hit_way_s;
        end else if (free_found_s) begin
            way_c = free_way_s;
        end else begin
            way_c = victim_way_s;
        end
    end

    // A store always lands in way_c, so refill words also refresh recency.
    cache_lru #(
        .SET_INDEX_WIDTH (SET_INDEX_WIDTH),
        .WAYS_WIDTH      (WAYS_WIDTH)
    ) u_lru (
        .clk        (clk),
        .rst        (rst),
        .set        (set_s),
        .touch_way  (way_c),
        .touch_en   (touch && (hit_c || store)),
        .victim_way (victim_way_s)
    );

    // Valid/dirty state: reset clears; invalid > store > edit.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    valid_r[s][w] <= 1'b0;
                    dirty_r[s][w] <= 1'b0;
                end
            end
        end else if (invalid) begin
            if (hit_c) begin
                valid_r[set_s][way_c] <= 1'b0;
                dirty_r[set_s][way_c] <= 1'b0;
            end
        end else if (store) begin
            valid_r[set_s][way_c] <= 1'b1;
            dirty_r[set_s][way_c] <= 1'b0;
        end else if (edit && hit_c) begin
            dirty_r[set_s][way_c] <= 1'b1;
        end
    end

    // Data and tag arrays: not reset, but writes are blocked while rst is high.
    always_ff @(posedge clk) begin
        if (!rst && !invalid && store) begin
            data_r[way_c][set_s][word_s] <= din;
            tag_r[way_c][set_s]          <= tag_s;
        end else if (!rst && !invalid && edit && hit_c) begin
            for (int b = 0; b < BYTES; b++) begin
                if (be[b]) begin
                    data_r[way_c][set_s][word_s][b*8 +: 8] <= din[b*8 +: 8];
                end
            end
        end
    end

    // Output registers: pre-update lookup result for addr.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit     <= 1'b0;
            sel_way <= '0;
            dout    <= '0;
            valid   <= 1'b0;
            dirty   <= 1'b0;
            tag     <= '0;
        end else begin
            hit     <= hit_c;
            sel_way <= way_c;
            dout    <= data_r[way_c][set_s][word_s];
            valid   <= valid_r[set_s][way_c];
            dirty   <= dirty_r[set_s][way_c];
            tag     <= tag_r[way_c][set_s];
        end
    end

endmodule
